udc_seg_scan: RTL

//  Display stage directly downstream of the up/down counter. Latches the counter's
//  4-bit value and direction, then drives a 4-digit multiplexed 7-segment display:

---
 rtl/udc_seg_scan.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/udc_seg_scan.sv
// Display stage for the up/down counter: captures value/direction and scans a
// 4-digit active-low 7-segment display with an anti-ghost blanking window.
module udc_seg_scan #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] value,
  input  logic       dir,
  input  logic       en,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic [1:0] slot,
  output logic       frame
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_UP   = 7'h41;
  localparam logic [6:0] SEG_DOWN = 7'h21;

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_slot;
  logic [3:0]    r_val_q;
  logic          r_dir_q;
  logic          r_wrap_q;
  logic [3:0]    r_sh_val;
  logic          r_sh_dir;
  logic          r_sh_wrap;
  logic [6:0]    r_seg;
  logic [3:0]    r_an;
  logic          r_frame;

  logic          w_last;
  logic [CW-1:0] w_cnt_next;
  logic [1:0]    w_slot_next;
  logic [3:0]    w_sh_val_next;
  logic          w_sh_dir_next;
  logic          w_sh_wrap_next;
  logic          w_wrap_now;
  logic          w_dark;
  logic [3:0]    w_an_lit;
  logic [6:0]    w_seg_next;
  logic [3:0]    w_an_next;

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0:    g = 7'h40;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h10;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h03;
      4'hC:    g = 7'h46;
      4'hD:    g = 7'h21;
      4'hE:    g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  assign w_last      = (r_cnt == CW'(REFRESH_DIV - 1));
  assign w_cnt_next  = w_last ? '0 : r_cnt + 1'b1;
  assign w_slot_next = w_last ? r_slot + 2'd1 : r_slot;

  // Shadow samples the pre-edge capture registers, so a boundary-cycle load lands one slot later.
  assign w_sh_val_next  = w_last ? r_val_q  : r_sh_val;
  assign w_sh_dir_next  = w_last ? r_dir_q  : r_sh_dir;
  assign w_sh_wrap_next = w_last ? r_wrap_q : r_sh_wrap;

  assign w_wrap_now = (dir  && (r_val_q == 4'hF) && (value == 4'h0)) ||
                      (!dir && (r_val_q == 4'h0) && (value == 4'hF));

  assign w_dark = !en || (w_cnt_next < CW'(BLANK_CYC));

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_an
      assign w_an_lit[gi] = (w_slot_next != 2'(gi));
    end
  endgenerate

  // Outputs are computed from the post-edge state so seg/an line up with cnt/slot.
  always_comb begin
    w_seg_next = SEG_OFF;
    w_an_next  = 4'hF;
    if (!w_dark) begin
      w_an_next = w_an_lit;
      case (w_slot_next)
        2'd0:    w_seg_next = hex_glyph(w_sh_val_next);
        2'd1:    w_seg_next = w_sh_wrap_next ? SEG_DASH : SEG_OFF;
        2'd2:    w_seg_next = SEG_OFF;
        default: w_seg_next = w_sh_dir_next ? SEG_UP : SEG_DOWN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_slot    <= 2'd0;
      r_val_q   <= 4'h0;
      r_dir_q   <= 1'b1;
      r_wrap_q  <= 1'b0;
      r_sh_val  <= 4'h0;
      r_sh_dir  <= 1'b1;
      r_sh_wrap <= 1'b0;
      r_seg     <= SEG_OFF;
      r_an      <= 4'hF;
      r_frame   <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_next;
      r_slot    <= w_slot_next;
      r_sh_val  <= w_sh_val_next;
      r_sh_dir  <= w_sh_dir_next;
      r_sh_wrap <= w_sh_wrap_next;
      if (load) begin
        r_val_q  <= value;
        r_dir_q  <= dir;
        r_wrap_q <= w_wrap_now;
      end
      r_seg   <= w_seg_next;
      r_an    <= w_an_next;
      r_frame <= w_last && (r_slot == 2'd3);
    end
  end

  assign seg   = r_seg;
  assign an    = r_an;
  assign slot  = r_slot;
  assign frame = r_frame;

endmodule
